seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Each digit slot starts with a blanking gap (all anodes off) to suppress
// ghosting, then shows that digit. Loaded values are staged in a shadow
// register and only reach the display register at a frame boundary, so a
// frame never tears. Pins are registered and follow state/index one cycle late.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        load,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  SEG,
  output logic [3:0]  AN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // With no blanking gap every slot is SHOW only, so slots start in SHOW.
  localparam state_e ST_START = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          tick_q, tick_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          boundary_s;
  logic          upper_zero_s;
  logic          lzb_hit_s;
  logic [3:0]    nib_s;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign boundary_s = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == 2'd3);
  assign nib_s      = disp_q[{idx_q, 2'b00} +: 4];
  assign lzb_hit_s  = lzb_en & upper_zero_s;

  // Current nibble and every higher nibble zero; digit 0 never qualifies.
  always_comb begin
    upper_zero_s = 1'b0;
    case (idx_q)
      2'd0:    upper_zero_s = 1'b0;
      2'd1:    upper_zero_s = (disp_q[15:4] == 12'h000);
      2'd2:    upper_zero_s = (disp_q[15:8] == 8'h00);
      2'd3:    upper_zero_s = (disp_q[15:12] == 4'h0);
      default: upper_zero_s = 1'b0;
    endcase
  end

  // Slot sequencing: BLANK gap, then SHOW until the slot ends, then next digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = ST_START;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_START;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Double buffering: a boundary load bypasses the shadow and drops any older pending value.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = boundary_s;
    if (boundary_s) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d   = data_in;
        shadow_d = data_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Pin values for the current slot; blanking gaps and suppressed leading zeros go dark.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if ((state_q == ST_SHOW) && !lzb_hit_s) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~dp_in[idx_q], hex7(nib_s)};
    end else begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end
  end

  // FSM state, slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Display/shadow buffers, pending flag, frame pulse and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q    <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign AN         = an_q;
  assign SEG        = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lzb_en = 1'b0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  int checks = 0;
  int errors = 0;
  int o = 0;  // cycles since the last observed frame_tick

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            lzb;
    logic [3:0]      blank;
    logic [3:0][7:0] seg;
  } vec_t;

  vec_t vecs [8];

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .lzb_en(lzb_en), .load(load), .pending(pending),
    .frame_tick(frame_tick), .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    o++;
  endtask

  task automatic adv(input int to);
    while (o < to) tick();
  endtask

  // Tick up to the next frame_tick (bounded) and restart the frame offset.
  task automatic sync();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_tick === 1'b1) break;
    end
    chk("sync_frame_tick", frame_tick, 1'b1);
    o = 0;
  endtask

  // Called just after rst_n rises on a negedge; display register is zero.
  task automatic startup();
    int m, slot, c;
    logic [3:0] ea;
    logic [7:0] es;
    for (int k = 1; k <= 33; k++) begin
      tick();
      m    = k - 1;
      slot = (m / 8) % 4;
      c    = m % 8;
      if (c >= 2) begin
        ea = 4'hF ^ (4'h1 << slot);
        es = 8'hC0;
      end else begin
        ea = 4'hF;
        es = 8'hFF;
      end
      chk($sformatf("start_an_k%0d", k), AN, ea);
      chk($sformatf("start_seg_k%0d", k), SEG, es);
      chk($sformatf("start_tick_k%0d", k), frame_tick, (k == 32) ? 1'b1 : 1'b0);
      chk($sformatf("start_pend_k%0d", k), pending, 1'b0);
    end
  endtask

  // Load a value mid-frame, confirm the frame-boundary handoff, then check each digit.
  task automatic run_vec(input int n, input vec_t v);
    logic [3:0] ea;
    sync();
    dp_in  = v.dp;
    lzb_en = v.lzb;
    adv(10);
    data_in = v.val;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk($sformatf("v%0d_pending_set", n), pending, 1'b1);
    adv(31);
    chk($sformatf("v%0d_pending_hold", n), pending, 1'b1);
    tick();
    chk($sformatf("v%0d_frame_tick", n), frame_tick, 1'b1);
    chk($sformatf("v%0d_pending_clr", n), pending, 1'b0);
    o = 0;
    for (int d = 0; d < 4; d++) begin
      adv(8 * d + 2);
      chk($sformatf("v%0d_d%0d_gap_an", n, d), AN, 4'hF);
      adv(8 * d + 5);
      ea = v.blank[d] ? 4'hF : (4'hF ^ (4'h1 << d));
      chk($sformatf("v%0d_d%0d_an", n, d), AN, ea);
      chk($sformatf("v%0d_d%0d_seg", n, d), SEG, v.seg[d]);
    end
  endtask

  initial begin
    vecs[0] = '{16'hABCD, 4'h0, 1'b0, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[1] = '{16'h0005, 4'h0, 1'b1, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
    vecs[2] = '{16'h0000, 4'h0, 1'b1, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{16'h0105, 4'h0, 1'b1, 4'b1000, {8'hFF, 8'hF9, 8'hC0, 8'h92}};
    vecs[4] = '{16'h8888, 4'h4, 1'b0, 4'b0000, {8'h80, 8'h00, 8'h80, 8'h80}};
    vecs[5] = '{16'h0105, 4'h0, 1'b0, 4'b0000, {8'hC0, 8'hF9, 8'hC0, 8'h92}};
    vecs[6] = '{16'hF0E7, 4'hF, 1'b1, 4'b0000, {8'h0E, 8'h40, 8'h06, 8'h78}};
    vecs[7] = '{16'h0005, 4'hF, 1'b1, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h12}};

    // Reset state while rst_n is held low
    #12;
    chk("rst_an", AN, 4'hF);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_pending", pending, 1'b0);
    chk("rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    startup();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Two loads in one frame: the later one wins
    dp_in  = 4'h0;
    lzb_en = 1'b0;
    sync();
    adv(5);
    data_in = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    adv(12);
    data_in = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    chk("dbl_pending", pending, 1'b1);
    adv(32);
    chk("dbl_tick", frame_tick, 1'b1);
    chk("dbl_pend_clr", pending, 1'b0);
    adv(37);
    chk("dbl_d0_an", AN, 4'hE);
    chk("dbl_d0_seg", SEG, 8'hA4);
    adv(61);
    chk("dbl_d3_an", AN, 4'h7);
    chk("dbl_d3_seg", SEG, 8'hA4);

    // Load on the boundary cycle goes straight to the display
    sync();
    adv(31);
    chk("bnd_pend_before", pending, 1'b0);
    data_in = 16'h3333; load = 1'b1; tick(); load = 1'b0;
    chk("bnd_tick", frame_tick, 1'b1);
    chk("bnd_pend_at", pending, 1'b0);
    tick();
    chk("bnd_pend_after", pending, 1'b0);
    adv(37);
    chk("bnd_d0_seg", SEG, 8'hB0);
    chk("bnd_pend_later", pending, 1'b0);
    adv(61);
    chk("bnd_d3_seg", SEG, 8'hB0);

    // Boundary load discards an older pending value
    sync();
    adv(10);
    data_in = 16'h4444; load = 1'b1; tick(); load = 1'b0;
    chk("disc_pending", pending, 1'b1);
    adv(31);
    data_in = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    chk("disc_tick", frame_tick, 1'b1);
    chk("disc_pend_clr", pending, 1'b0);
    adv(37);
    chk("disc_d0_seg", SEG, 8'h92);
    adv(69);
    chk("disc_next_d0_seg", SEG, 8'h92);
    chk("disc_next_pend", pending, 1'b0);

    // Asynchronous reset four cycles into digit 1 SHOW
    sync();
    adv(14);
    chk("mid_pre_an", AN, 4'hD);
    chk("mid_pre_seg", SEG, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", AN, 4'hF);
    chk("mid_rst_seg", SEG, 8'hFF);
    chk("mid_rst_pend", pending, 1'b0);
    chk("mid_rst_tick", frame_tick, 1'b0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    startup();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
